i2c_byte_tx: RTL and testbench

Controller-side I2C byte transmitter, the driving end of the bus that the I2C detector observes. It accepts byte commands through a valid/ready handshake and generates the bus waveforms for each one: optional START or repeated START, 8 data bits MSB first, a released ACK slot, and an optional STOP. SCL and SDA are produced as open-drain "release" levels, with 1 meaning released (high) and 0 meaning driven low. The ACK bit is sampled from `sda_in`, and one done pulse is issued per command.

---
 rtl/myfilter_pkg.sv | 44 ++++
 rtl/i2c_byte_tx_if.sv | 27 ++
 rtl/i2c_phase_timer.sv | 26 ++
 rtl/i2c_byte_tx.sv | 126 ++++++++++++
 tb/tb_i2c_byte_tx.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/myfilter_pkg.sv
// myfilter_pkg: shared types and constants for the I2C byte transmitter
package myfilter_pkg;

    localparam int   I2C_BYTE_W = 8;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RS_A,
        ST_RS_B,
        ST_START_A,
        ST_START_B,
        ST_BIT_LO,
        ST_BIT_HI,
        ST_ACK_LO,
        ST_ACK_HI,
        ST_STOP_A,
        ST_STOP_B,
        ST_STOP_C,
        ST_HOLD
    } i2c_tx_state_t;

    // Bus release levels {scl, sda} for a state; d is the current data bit.
    // In the ACK slot SDA is released, which reads as NACK unless the target pulls it low.
    function automatic logic [1:0] tx_levels(input i2c_tx_state_t s, input logic d);
        case (s)
            ST_RS_A:    tx_levels = 2'b01;
            ST_RS_B:    tx_levels = 2'b11;
            ST_START_A: tx_levels = 2'b10;
            ST_START_B: tx_levels = 2'b00;
            ST_BIT_LO:  tx_levels = {1'b0, d};
            ST_BIT_HI:  tx_levels = {1'b1, d};
            ST_ACK_LO:  tx_levels = {1'b0, I2C_NACK};
            ST_ACK_HI:  tx_levels = {1'b1, I2C_NACK};
            ST_STOP_A:  tx_levels = 2'b00;
            ST_STOP_B:  tx_levels = 2'b10;
            ST_STOP_C:  tx_levels = 2'b11;
            ST_HOLD:    tx_levels = 2'b01;
            default:    tx_levels = 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/i2c_byte_tx_if.sv
// i2c_byte_tx_if: command handshake and bus-level signals of the byte transmitter
interface i2c_byte_tx_if;
    import myfilter_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_start;
    logic                  cmd_stop;
    logic [I2C_BYTE_W-1:0] cmd_data;
    logic                  sda_in;
    logic                  scl_out;
    logic                  sda_out;
    logic                  busy_out;
    logic                  done_out;
    logic                  ack_out;

    modport master (
        output cmd_valid, cmd_start, cmd_stop, cmd_data, sda_in,
        input  cmd_ready, scl_out, sda_out, busy_out, done_out, ack_out
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_stop, cmd_data, sda_in,
        output cmd_ready, scl_out, sda_out, busy_out, done_out, ack_out
    );

endinterface

// File: rtl/i2c_phase_timer.sv
// i2c_phase_timer: times each bus state to HALF_PERIOD cycles, flagging its last cycle
module i2c_phase_timer #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic state_chg,
    output logic phase_end
);

    localparam int            CW     = $clog2(HALF_PERIOD + 1);
    localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Reload on every state change, otherwise count down and rest at zero
    always_comb cnt_d = state_chg ? RELOAD : (cnt_q == '0 ? cnt_q : cnt_q - CW'(1));

    // Counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= RELOAD;
        else        cnt_q <= cnt_d;

    assign phase_end = cnt_q == '0;

endmodule

// File: rtl/i2c_byte_tx.sv
// i2c_byte_tx: controller-side I2C byte transmitter with START/repeated START/STOP
module i2c_byte_tx
    import myfilter_pkg::*;
#(
    parameter int HALF_PERIOD = 4
) (
    input logic          clk,
    input logic          rst_n,
    i2c_byte_tx_if.slave bus
);

    i2c_tx_state_t         state_q, state_d;
    logic [I2C_BYTE_W-1:0] data_q, data_d;
    logic [2:0]            bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic                  ack_s_q, ack_s_d;
    logic                  ack_q, ack_d;
    logic                  done_q, done_d;
    logic                  scl_q, scl_d;
    logic                  sda_q, sda_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  phase_end;
    logic                  accept;
    logic                  ack_bit;

    assign accept  = bus.cmd_valid && ready_q;
    assign ack_bit = bus.sda_in == I2C_ACK;

    i2c_phase_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .state_chg (state_d != state_q),
        .phase_end (phase_end)
    );

    // Next state, command capture, ACK capture, and output levels of the next state
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        ack_s_d = ack_s_q;
        ack_d   = ack_q;
        done_d  = 1'b0;
        if (accept) begin
            data_d = bus.cmd_data;
            stop_d = bus.cmd_stop;
            bit_d  = 3'd7;
        end
        case (state_q)
            ST_IDLE:    state_d = accept ? ST_START_A : ST_IDLE;
            ST_HOLD:    state_d = !accept ? ST_HOLD : (bus.cmd_start ? ST_RS_A : ST_BIT_LO);
            ST_RS_A:    state_d = phase_end ? ST_RS_B : state_q;
            ST_RS_B:    state_d = phase_end ? ST_START_A : state_q;
            ST_START_A: state_d = phase_end ? ST_START_B : state_q;
            ST_START_B: state_d = phase_end ? ST_BIT_LO : state_q;
            ST_BIT_LO:  state_d = phase_end ? ST_BIT_HI : state_q;
            ST_BIT_HI: begin
                if (phase_end) begin
                    state_d = bit_q == 3'd0 ? ST_ACK_LO : ST_BIT_LO;
                    bit_d   = bit_q - 3'd1;
                end
            end
            ST_ACK_LO:  state_d = phase_end ? ST_ACK_HI : state_q;
            ST_ACK_HI: begin
                if (phase_end) begin
                    state_d = stop_q ? ST_STOP_A : ST_HOLD;
                    ack_s_d = ack_bit;
                    ack_d   = stop_q ? ack_q : ack_bit;
                    done_d  = !stop_q;
                end
            end
            ST_STOP_A:  state_d = phase_end ? ST_STOP_B : state_q;
            ST_STOP_B:  state_d = phase_end ? ST_STOP_C : state_q;
            ST_STOP_C: begin
                if (phase_end) begin
                    state_d = ST_IDLE;
                    ack_d   = ack_s_q;
                    done_d  = 1'b1;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
        {scl_d, sda_d} = tx_levels(state_d, data_d[bit_d]);
        ready_d = state_d == ST_IDLE || state_d == ST_HOLD;
        busy_d  = state_d != ST_IDLE;
    end

    // State and registered outputs; reset releases both lines at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            bit_q   <= 3'd7;
            stop_q  <= 1'b0;
            ack_s_q <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            ack_s_q <= ack_s_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.scl_out   = scl_q;
    assign bus.sda_out   = sda_q;
    assign bus.busy_out  = busy_q;
    assign bus.done_out  = done_q;
    assign bus.ack_out   = ack_q;

endmodule

// File: tb/tb_i2c_byte_tx.sv
// tb_i2c_byte_tx: directed and randomized checks of the I2C byte transmitter
module tb_i2c_byte_tx;
    import myfilter_pkg::*;

    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    i2c_byte_tx_if bus ();

    i2c_byte_tx #(.HALF_PERIOD(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    int          done_cyc, rises, starts, stops, start_rise;
    logic [15:0] shreg;
    logic        first_scl, first_sda;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command from a negedge and watch the bus until done_out (bounded)
    task automatic run_cmd(input logic [7:0] d, input logic st, input logic sp, input logic ack_lvl);
        logic ps, pd;
        int   cyc;
        ps = bus.scl_out;
        pd = bus.sda_out;
        rises = 0; starts = 0; stops = 0; start_rise = -1; done_cyc = -1; shreg = '0;
        bus.cmd_data = d; bus.cmd_start = st; bus.cmd_stop = sp; bus.sda_in = ack_lvl;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        cyc = 1;
        while (cyc < 400 && done_cyc < 0) begin
            @(negedge clk);
            if (cyc == 1) begin
                first_scl = bus.scl_out;
                first_sda = bus.sda_out;
            end
            if (!ps && bus.scl_out) begin
                rises++;
                shreg = {shreg[14:0], bus.sda_out};
            end
            if (ps && bus.scl_out && pd && !bus.sda_out) begin
                starts++;
                if (start_rise < 0) start_rise = rises;
            end
            if (ps && bus.scl_out && !pd && bus.sda_out) stops++;
            ps = bus.scl_out;
            pd = bus.sda_out;
            if (bus.done_out) done_cyc = cyc;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        chk("done_seen", done_cyc >= 0, 1);
    endtask

    initial begin
        logic        held, st, sp, a;
        logic [7:0]  d;
        int          exp_dur, off, seen;
        bus.cmd_valid = 1'b0; bus.cmd_start = 1'b0; bus.cmd_stop = 1'b0;
        bus.cmd_data = 8'h00; bus.sda_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_scl", bus.scl_out, 1);
        chk("rst_sda", bus.sda_out, 1);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy_out, 0);
        chk("rst_done", bus.done_out, 0);
        chk("rst_ack", bus.ack_out, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full byte with STOP from idle: 23*H cycles, ACK driven low
        run_cmd(8'hA5, 1'b1, 1'b1, 1'b0);
        chk("t1_done_cyc", done_cyc, 93);
        chk("t1_bits", shreg[9:0], 10'h296);
        chk("t1_rises", rises, 10);
        chk("t1_starts", starts, 1);
        chk("t1_start_rise", start_rise, 0);
        chk("t1_stops", stops, 1);
        chk("t1_ack", bus.ack_out, 1);
        chk("t1_scl", bus.scl_out, 1);
        chk("t1_sda", bus.sda_out, 1);
        chk("t1_busy", bus.busy_out, 0);
        chk("t1_ready", bus.cmd_ready, 1);

        // NACK and hold
        run_cmd(8'hFF, 1'b1, 1'b0, 1'b1);
        chk("t2_done_cyc", done_cyc, 81);
        chk("t2_ready", bus.cmd_ready, 1);
        chk("t2_bits", shreg[8:0], 9'h1FF);
        chk("t2_stops", stops, 0);
        chk("t2_ack", bus.ack_out, 0);
        repeat (5) @(negedge clk);
        chk("t2_hold_scl", bus.scl_out, 0);
        chk("t2_hold_sda", bus.sda_out, 1);
        chk("t2_hold_busy", bus.busy_out, 1);

        // Repeated START from hold
        run_cmd(8'h3C, 1'b1, 1'b1, 1'b0);
        chk("t3_done_cyc", done_cyc, 101);
        chk("t3_bits", shreg[10:0], 11'h4F2);
        chk("t3_starts", starts, 1);
        chk("t3_start_rise", start_rise, 1);
        chk("t3_stops", stops, 1);
        chk("t3_ack", bus.ack_out, 1);

        // Back into hold, then back-to-back data without START
        run_cmd(8'h5A, 1'b1, 1'b0, 1'b0);
        chk("t4a_done_cyc", done_cyc, 81);
        run_cmd(8'h00, 1'b0, 1'b0, 1'b1);
        chk("t4_done_cyc", done_cyc, 73);
        chk("t4_first_scl", first_scl, 0);
        chk("t4_first_sda", first_sda, 0);
        chk("t4_starts", starts, 0);
        chk("t4_rises", rises, 9);
        chk("t4_bits", shreg[8:0], 9'h001);
        chk("t4_ack", bus.ack_out, 0);
        run_cmd(8'hC3, 1'b0, 1'b1, 1'b0);
        chk("t4b_done_cyc", done_cyc, 85);
        chk("t4b_bits", shreg[9:0], 10'h30E);
        chk("t4b_starts", starts, 0);
        chk("t4b_stops", stops, 1);
        chk("t4b_ack", bus.ack_out, 1);
        chk("t4b_busy", bus.busy_out, 0);

        // Busy-time command ignored, then reset during BIT_HI of bit 4
        bus.cmd_data = 8'hA5; bus.cmd_start = 1'b1; bus.cmd_stop = 1'b1; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1 begin bus.cmd_valid = 1'b1; bus.cmd_data = 8'hFF; end
        @(negedge clk);
        chk("t5_busy_ready", bus.cmd_ready, 0);
        repeat (18) @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t5_bit4_scl", bus.scl_out, 1);
        chk("t5_bit4_sda", bus.sda_out, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_scl", bus.scl_out, 1);
        chk("t5_rst_sda", bus.sda_out, 1);
        chk("t5_rst_busy", bus.busy_out, 0);
        chk("t5_rst_ready", bus.cmd_ready, 1);
        chk("t5_rst_ack", bus.ack_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.done_out) seen++;
        end
        chk("t5_no_done", seen, 0);
        chk("t5_idle_scl", bus.scl_out, 1);
        chk("t5_idle_sda", bus.sda_out, 1);

        // Randomized protocol cross-check against a bus-level model
        held = 1'b0;
        for (int i = 0; i < 40; i++) begin
            d  = 8'($urandom);
            st = 1'($urandom_range(0, 1));
            sp = 1'($urandom_range(0, 1));
            a  = 1'($urandom_range(0, 1));
            run_cmd(d, st, sp, a);
            exp_dur = (held ? (st ? 22 * H : 18 * H) : 20 * H) + (sp ? 3 * H : 0);
            off = sp ? 2 : 1;
            chk("rnd_dur", done_cyc, exp_dur + 1);
            chk("rnd_rises", rises, 9 + ((held && st) ? 1 : 0) + (sp ? 1 : 0));
            chk("rnd_starts", starts, (!held || st) ? 1 : 0);
            chk("rnd_stops", stops, sp ? 1 : 0);
            chk("rnd_bits", shreg[off +: 8], d);
            chk("rnd_ack", bus.ack_out, !a);
            chk("rnd_scl", bus.scl_out, sp);
            chk("rnd_sda", bus.sda_out, 1);
            held = !sp;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
